// File: rtl/ap_prof_pkg.sv
// ---------------------------------------------------------------------------
// ap_prof_pkg
// Shared types and helpers for the ap_ctrl_chain handshake profiler.
//   metric_e   : read-back metric select codes driven on rd_sel
//   ch_state_e : per-channel occupancy state (IDLE / ACTIVE / FULL)
//   lat_sat    : clamps a cycle difference to the latency result width
// ---------------------------------------------------------------------------
package ap_prof_pkg;

    typedef enum logic [2:0] {
        METRIC_TXN_IN   = 3'd0,
        METRIC_TXN_OUT  = 3'd1,
        METRIC_BUSY     = 3'd2,
        METRIC_STALL    = 3'd3,
        METRIC_MIN_LAT  = 3'd4,
        METRIC_MAX_LAT  = 3'd5,
        METRIC_LAST_LAT = 3'd6,
        METRIC_OCC      = 3'd7
    } metric_e;

    typedef enum logic [1:0] {
        CH_IDLE   = 2'd0,
        CH_ACTIVE = 2'd1,
        CH_FULL   = 2'd2
    } ch_state_e;

    // Clamp a (zero-extended) cycle difference to 2^lat_w - 1; lat_w < 64.
    function automatic logic [63:0] lat_sat(input logic [63:0] diff, input int unsigned lat_w);
        logic [63:0] lim;
        lim = (64'd1 << lat_w) - 64'd1;
        if (diff > lim) begin
            lat_sat = lim;
        end else begin
            lat_sat = diff;
        end
    endfunction

endpackage

// File: rtl/ap_prof_channel.sv
// ---------------------------------------------------------------------------
// ap_prof_channel
// Statistics engine for one ap_ctrl_chain handshake group: a timestamp FIFO
// of outstanding transactions plus saturating counters and latency results.
// Ports:
//   clock, reset    : clock, synchronous active-high reset
//   clear, frozen   : statistics clear, hold-all-state while frozen
//   ts              : current free-running timestamp
//   start/ready     : accept handshake (ap_start & ap_ready)
//   done/cont       : complete handshake (ap_done & ap_continue)
//   rd_sel / rd_val : metric select and combinational selected value
//   idle            : FIFO empty (channel state CH_IDLE)
//   err             : sticky protocol error
// ---------------------------------------------------------------------------
module ap_prof_channel
    import ap_prof_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int LAT_W   = 16,
    parameter int MAX_OUT = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             frozen,
    input  logic [CNT_W-1:0] ts,
    input  logic             start,
    input  logic             ready,
    input  logic             done,
    input  logic             cont,
    input  logic [2:0]       rd_sel,
    output logic [CNT_W-1:0] rd_val,
    output logic             idle,
    output logic             err
);

    localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int OCC_W = $clog2(MAX_OUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);
    localparam logic [LAT_W-1:0] LAT_MAX = {LAT_W{1'b1}};

    logic [CNT_W-1:0] mem_r [MAX_OUT];
    logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
    logic [OCC_W-1:0] occ_r;
    ch_state_e        state_r;
    logic [CNT_W-1:0] txn_in_r, txn_out_r, busy_r, stall_r;
    logic [LAT_W-1:0] min_lat_r, max_lat_r, last_lat_r;
    logic             err_r;

    logic             acc_s, cmp_s, empty_s, full_s;
    logic             pop_s, push_s, zero_s, acc_err_s, cmp_err_s;
    logic             acc_ok_s, cpl_ok_s;
    logic [CNT_W-1:0] diff_s;
    logic [LAT_W-1:0] lat_s;
    logic [OCC_W-1:0] occ_nxt_s;
    logic [PTR_W-1:0] wr_ptr_nxt_s, rd_ptr_nxt_s;
    ch_state_e        state_nxt_s;

    // Event decode: which handshakes are honoured and which are protocol errors.
    always_comb begin
        acc_s   = start & ready;
        cmp_s   = done & cont;
        empty_s = (occ_r == {OCC_W{1'b0}});
        full_s  = (occ_r == OCC_W'(MAX_OUT));
        pop_s   = cmp_s & ~empty_s;
        // Accept and complete on an empty FIFO is a zero-latency pass-through.
        zero_s  = cmp_s & empty_s & acc_s;
        // A same-cycle pop frees a slot, so a full FIFO may still take the push.
        push_s    = acc_s & ~zero_s & (~full_s | pop_s);
        acc_err_s = acc_s & full_s & ~pop_s;
        cmp_err_s = cmp_s & empty_s & ~acc_s;
        acc_ok_s  = push_s | zero_s;
        cpl_ok_s  = pop_s | zero_s;
    end

    // Latency of the completing transaction, clamped to the result width.
    always_comb begin
        diff_s = ts - mem_r[rd_ptr_r];
        if (zero_s) begin
            lat_s = {LAT_W{1'b0}};
        end else begin
            lat_s = LAT_W'(lat_sat(64'(diff_s), LAT_W));
        end
    end

    // Next FIFO pointers, occupancy and derived channel state.
    always_comb begin
        wr_ptr_nxt_s = (wr_ptr_r == PTR_W'(MAX_OUT - 1)) ? {PTR_W{1'b0}} : wr_ptr_r + PTR_W'(1'b1);
        rd_ptr_nxt_s = (rd_ptr_r == PTR_W'(MAX_OUT - 1)) ? {PTR_W{1'b0}} : rd_ptr_r + PTR_W'(1'b1);
        case ({push_s, pop_s})
            2'b10:   occ_nxt_s = occ_r + OCC_W'(1'b1);
            2'b01:   occ_nxt_s = occ_r - OCC_W'(1'b1);
            default: occ_nxt_s = occ_r;
        endcase
        if (occ_nxt_s == {OCC_W{1'b0}}) begin
            state_nxt_s = CH_IDLE;
        end else if (occ_nxt_s == OCC_W'(MAX_OUT)) begin
            state_nxt_s = CH_FULL;
        end else begin
            state_nxt_s = CH_ACTIVE;
        end
    end

    // FIFO, statistics and error flag; everything holds while frozen.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            for (int i = 0; i < MAX_OUT; i++) begin
                mem_r[i] <= {CNT_W{1'b0}};
            end
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            occ_r      <= {OCC_W{1'b0}};
            state_r    <= CH_IDLE;
            txn_in_r   <= {CNT_W{1'b0}};
            txn_out_r  <= {CNT_W{1'b0}};
            busy_r     <= {CNT_W{1'b0}};
            stall_r    <= {CNT_W{1'b0}};
            min_lat_r  <= LAT_MAX;
            max_lat_r  <= {LAT_W{1'b0}};
            last_lat_r <= {LAT_W{1'b0}};
            err_r      <= 1'b0;
        end else if (!frozen) begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= ts;
                wr_ptr_r        <= wr_ptr_nxt_s;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_nxt_s;
            end
            occ_r   <= occ_nxt_s;
            state_r <= state_nxt_s;
            if (acc_ok_s && (txn_in_r != CNT_MAX)) begin
                txn_in_r <= txn_in_r + CNT_ONE;
            end
            if (cpl_ok_s) begin
                if (txn_out_r != CNT_MAX) begin
                    txn_out_r <= txn_out_r + CNT_ONE;
                end
                last_lat_r <= lat_s;
                if (lat_s > max_lat_r) begin
                    max_lat_r <= lat_s;
                end
                if (lat_s < min_lat_r) begin
                    min_lat_r <= lat_s;
                end
            end
            if (!empty_s && (busy_r != CNT_MAX)) begin
                busy_r <= busy_r + CNT_ONE;
            end
            if (done && !cont && (stall_r != CNT_MAX)) begin
                stall_r <= stall_r + CNT_ONE;
            end
            if (acc_err_s || cmp_err_s) begin
                err_r <= 1'b1;
            end
        end
    end

    // Metric select for the top-level readout register.
    always_comb begin
        case (metric_e'(rd_sel))
            METRIC_TXN_IN:   rd_val = txn_in_r;
            METRIC_TXN_OUT:  rd_val = txn_out_r;
            METRIC_BUSY:     rd_val = busy_r;
            METRIC_STALL:    rd_val = stall_r;
            METRIC_MIN_LAT:  rd_val = CNT_W'(min_lat_r);
            METRIC_MAX_LAT:  rd_val = CNT_W'(max_lat_r);
            METRIC_LAST_LAT: rd_val = CNT_W'(last_lat_r);
            METRIC_OCC:      rd_val = CNT_W'(occ_r);
            default:         rd_val = {CNT_W{1'b0}};
        endcase
    end

    assign idle = (state_r == CH_IDLE);
    assign err  = err_r;

endmodule

// File: rtl/ap_ctrl_profiler.sv
// ---------------------------------------------------------------------------
// ap_ctrl_profiler
// Multi-channel ap_ctrl_chain handshake profiler. Holds the shared timestamp,
// the sticky freeze flag and the registered metric readout; per-channel
// statistics live in ap_prof_channel instances.
// Ports:
//   clock, reset          : clock, synchronous active-high reset
//   finish                : end-of-run, freezes statistics from the next edge
//   clear                 : synchronous statistics clear (leaves rd_data alone)
//   ch_start/ch_ready     : per-channel accept handshake
//   ch_done/ch_continue   : per-channel complete handshake
//   rd_ch, rd_sel         : channel and metric to read
//   rd_data, rd_valid     : registered metric (zero-extended) and its valid
//   err                   : sticky per-channel protocol error
//   frozen, all_idle      : freeze status, no outstanding transactions
// ---------------------------------------------------------------------------
module ap_ctrl_profiler
    import ap_prof_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 32,
    parameter int LAT_W   = 16,
    parameter int MAX_OUT = 4,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              finish,
    input  logic              clear,
    input  logic [NUM_CH-1:0] ch_start,
    input  logic [NUM_CH-1:0] ch_ready,
    input  logic [NUM_CH-1:0] ch_done,
    input  logic [NUM_CH-1:0] ch_continue,
    input  logic [CH_W-1:0]   rd_ch,
    input  logic [2:0]        rd_sel,
    output logic [CNT_W-1:0]  rd_data,
    output logic              rd_valid,
    output logic [NUM_CH-1:0] err,
    output logic              frozen,
    output logic              all_idle
);

    logic [CNT_W-1:0]  ts_r;
    logic              frozen_r;
    logic [CNT_W-1:0]  rd_data_r;
    logic              rd_valid_r;
    logic [CNT_W-1:0]  ch_val_s [NUM_CH];
    logic [NUM_CH-1:0] ch_idle_s;
    logic [NUM_CH-1:0] ch_err_s;
    logic [CNT_W-1:0]  sel_val_s;

    // Free-running timestamp (wraps) and sticky freeze flag.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            ts_r     <= {CNT_W{1'b0}};
            frozen_r <= 1'b0;
        end else begin
            if (!frozen_r) begin
                ts_r <= ts_r + CNT_W'(1'b1);
            end
            if (finish) begin
                frozen_r <= 1'b1;
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_ch
            ap_prof_channel #(
                .CNT_W   (CNT_W),
                .LAT_W   (LAT_W),
                .MAX_OUT (MAX_OUT)
            ) u_ch (
                .clock  (clock),
                .reset  (reset),
                .clear  (clear),
                .frozen (frozen_r),
                .ts     (ts_r),
                .start  (ch_start[g]),
                .ready  (ch_ready[g]),
                .done   (ch_done[g]),
                .cont   (ch_continue[g]),
                .rd_sel (rd_sel),
                .rd_val (ch_val_s[g]),
                .idle   (ch_idle_s[g]),
                .err    (ch_err_s[g])
            );
        end
    endgenerate

    // Channel select; an rd_ch beyond NUM_CH reads as zero.
    always_comb begin
        sel_val_s = {CNT_W{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_ch == CH_W'(i)) begin
                sel_val_s = ch_val_s[i];
            end else begin
                sel_val_s = sel_val_s;
            end
        end
    end

    // Readout register; clear deliberately leaves it alone.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_data_r  <= {CNT_W{1'b0}};
            rd_valid_r <= 1'b0;
        end else begin
            rd_data_r  <= sel_val_s;
            rd_valid_r <= 1'b1;
        end
    end

    assign rd_data  = rd_data_r;
    assign rd_valid = rd_valid_r;
    assign err      = ch_err_s;
    assign frozen   = frozen_r;
    assign all_idle = &ch_idle_s;

endmodule

// File: tb/tb_ap_ctrl_profiler.sv
module tb_ap_ctrl_profiler;

    localparam int NCH = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1, finish = 1'b0, clear = 1'b0;
    logic [3:0]  start = 4'h0, ready = 4'h0, done = 4'h0, cont = 4'hF;
    logic [1:0]  rd_ch = 2'd0;
    logic [2:0]  rd_sel = 3'd0;
    logic [31:0] rd_data;
    logic        rd_valid, frozen, all_idle;
    logic [3:0]  err;

    // Narrow-counter instance for saturation checks.
    logic        s_clear = 1'b0, s_finish = 1'b0;
    logic [0:0]  s_start = 1'b0, s_ready = 1'b0, s_done = 1'b0, s_cont = 1'b1;
    logic [0:0]  s_rd_ch = 1'b0;
    logic [2:0]  s_rd_sel = 3'd0;
    logic [3:0]  s_rd_data;
    logic        s_rd_valid, s_frozen, s_all_idle;
    logic [0:0]  s_err;

    int n_checks = 0;
    int n_bad    = 0;

    ap_ctrl_profiler #(.NUM_CH(4), .CNT_W(32), .LAT_W(16), .MAX_OUT(4)) dut (
        .clock(clock), .reset(reset), .finish(finish), .clear(clear),
        .ch_start(start), .ch_ready(ready), .ch_done(done), .ch_continue(cont),
        .rd_ch(rd_ch), .rd_sel(rd_sel), .rd_data(rd_data), .rd_valid(rd_valid),
        .err(err), .frozen(frozen), .all_idle(all_idle)
    );

    ap_ctrl_profiler #(.NUM_CH(1), .CNT_W(4), .LAT_W(4), .MAX_OUT(2)) dut_s (
        .clock(clock), .reset(reset), .finish(s_finish), .clear(s_clear),
        .ch_start(s_start), .ch_ready(s_ready), .ch_done(s_done), .ch_continue(s_cont),
        .rd_ch(s_rd_ch), .rd_sel(s_rd_sel), .rd_data(s_rd_data), .rd_valid(s_rd_valid),
        .err(s_err), .frozen(s_frozen), .all_idle(s_all_idle)
    );

    always #5 clock = ~clock;

    // ---------------- reference model (transaction level) ----------------
    bit [31:0] m_ts;
    bit        m_frozen;
    bit [31:0] m_q [NCH][$];
    bit [31:0] m_in [NCH], m_out [NCH], m_busy [NCH], m_stall [NCH];
    bit [15:0] m_min [NCH], m_max [NCH], m_last [NCH];
    bit [3:0]  m_err;

    function automatic bit [31:0] sinc(bit [31:0] x);
        return (x == 32'hFFFF_FFFF) ? x : x + 32'd1;
    endfunction

    task automatic model_clear();
        for (int c = 0; c < NCH; c++) begin
            m_q[c].delete();
            m_in[c] = 0; m_out[c] = 0; m_busy[c] = 0; m_stall[c] = 0;
            m_min[c] = 16'hFFFF; m_max[c] = 0; m_last[c] = 0;
        end
        m_ts = 0; m_frozen = 0; m_err = 0;
    endtask

    task automatic model_complete(int c, bit [15:0] lat);
        m_out[c]  = sinc(m_out[c]);
        m_last[c] = lat;
        if (lat > m_max[c]) m_max[c] = lat;
        if (lat < m_min[c]) m_min[c] = lat;
    endtask

    task automatic model_step();
        if (reset || clear) begin
            model_clear();
            return;
        end
        if (!m_frozen) begin
            for (int c = 0; c < NCH; c++) begin
                bit acc = start[c] & ready[c];
                bit cmp = done[c] & cont[c];
                int n   = m_q[c].size();
                bit [31:0] d;
                if (n > 0) m_busy[c] = sinc(m_busy[c]);
                if (done[c] && !cont[c]) m_stall[c] = sinc(m_stall[c]);
                if (cmp && n > 0) begin
                    d = m_ts - m_q[c].pop_front();
                    model_complete(c, (d > 32'd65535) ? 16'hFFFF : d[15:0]);
                    if (acc) begin
                        m_q[c].push_back(m_ts);
                        m_in[c] = sinc(m_in[c]);
                    end
                end else if (cmp && acc) begin
                    model_complete(c, 16'd0);
                    m_in[c] = sinc(m_in[c]);
                end else if (cmp) begin
                    m_err[c] = 1'b1;
                end else if (acc) begin
                    if (n == 4) begin
                        m_err[c] = 1'b1;
                    end else begin
                        m_q[c].push_back(m_ts);
                        m_in[c] = sinc(m_in[c]);
                    end
                end
            end
            m_ts = m_ts + 32'd1;
        end
        if (finish) m_frozen = 1'b1;
    endtask

    function automatic bit [31:0] model_metric(int c, int sel);
        case (sel)
            0: return m_in[c];
            1: return m_out[c];
            2: return m_busy[c];
            3: return m_stall[c];
            4: return {16'd0, m_min[c]};
            5: return {16'd0, m_max[c]};
            6: return {16'd0, m_last[c]};
            default: return 32'(m_q[c].size());
        endcase
    endfunction

    function automatic bit model_idle();
        for (int c = 0; c < NCH; c++) if (m_q[c].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1; tick(); clear = 1'b0;
    endtask

    task automatic rd_metric(input int c, input int sel, output bit [31:0] exp_v, output logic [31:0] got);
        rd_ch  = 2'(c);
        rd_sel = 3'(sel);
        exp_v  = model_metric(c, sel);
        tick();
        got = rd_data;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        bit [31:0] e; logic [31:0] g;
        reset = 1'b1; tick(); tick();
        n_checks++;
        if (rd_valid !== 1'b0 || rd_data !== 32'd0 || err !== 4'd0 || frozen !== 1'b0 || all_idle !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_outputs got valid=%b data=%0h err=%b frozen=%b idle=%b exp 0/0/0/0/1",
                     rd_valid, rd_data, err, frozen, all_idle);
        end
        reset = 1'b0;
        rd_metric(0, 4, e, g);
        n_checks++;
        if (g !== 32'h0000_FFFF || rd_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_min_lat got=%0h valid=%b exp=ffff valid=1", g, rd_valid);
        end
        rd_metric(2, 0, e, g);
        n_checks++;
        if (g !== 32'd0) begin n_bad++; $display("FAIL reset_txn_in got=%0d exp=0", g); end
    endtask

    task automatic test_single();
        int unsigned tab [7] = '{1, 1, 7, 0, 7, 7, 7};
        bit [31:0] e; logic [31:0] g;
        do_clear();
        start[0] = 1'b1; ready[0] = 1'b1; tick();
        start[0] = 1'b0; ready[0] = 1'b0;
        repeat (6) tick();
        done[0] = 1'b1; tick(); done[0] = 1'b0;
        for (int s = 0; s < 7; s++) begin
            rd_metric(0, s, e, g);
            n_checks++;
            if (g !== tab[s]) begin n_bad++; $display("FAIL single sel=%0d got=%0d exp=%0d", s, g, tab[s]); end
        end
        n_checks++;
        if (err !== 4'd0) begin n_bad++; $display("FAIL single_err got=%b exp=0000", err); end
    endtask

    task automatic test_pipelined();
        int unsigned tab [8] = '{4, 4, 8, 0, 5, 5, 5, 0};
        bit [31:0] e; logic [31:0] g;
        do_clear();
        start[1] = 1'b1; ready[1] = 1'b1;
        repeat (4) tick();
        rd_ch = 2'd1; rd_sel = 3'd7;
        tick();                                   // 5th accept while full
        n_checks++;
        if (rd_data !== 32'd4) begin n_bad++; $display("FAIL pipe_peak_occ got=%0d exp=4", rd_data); end
        start[1] = 1'b0; ready[1] = 1'b0;
        done[1] = 1'b1; repeat (4) tick(); done[1] = 1'b0;
        for (int s = 0; s < 8; s++) begin
            rd_metric(1, s, e, g);
            n_checks++;
            if (g !== tab[s]) begin n_bad++; $display("FAIL pipe sel=%0d got=%0d exp=%0d", s, g, tab[s]); end
        end
        n_checks++;
        if (err !== 4'b0010) begin n_bad++; $display("FAIL pipe_err got=%b exp=0010", err); end
    endtask

    task automatic test_stall();
        int unsigned tab [7] = '{1, 1, 4, 3, 4, 4, 4};
        bit [31:0] e; logic [31:0] g;
        do_clear();
        start[2] = 1'b1; ready[2] = 1'b1; tick();
        start[2] = 1'b0; ready[2] = 1'b0;
        done[2] = 1'b1; cont[2] = 1'b0; repeat (3) tick();
        cont[2] = 1'b1; tick(); done[2] = 1'b0;
        for (int s = 0; s < 7; s++) begin
            rd_metric(2, s, e, g);
            n_checks++;
            if (g !== tab[s]) begin n_bad++; $display("FAIL stall sel=%0d got=%0d exp=%0d", s, g, tab[s]); end
        end
    endtask

    task automatic test_freeze();
        int unsigned sels [5] = '{0, 1, 2, 7, 2};
        int unsigned tab  [5] = '{1, 0, 4, 1, 4};
        bit [31:0] e; logic [31:0] g;
        do_clear();
        start[0] = 1'b1; ready[0] = 1'b1; tick();
        start[0] = 1'b0; ready[0] = 1'b0;
        repeat (3) tick();
        finish = 1'b1; tick(); finish = 1'b0;
        n_checks++;
        if (frozen !== 1'b1) begin n_bad++; $display("FAIL freeze_flag got=%b exp=1", frozen); end
        done[0] = 1'b1; start[3] = 1'b1; ready[3] = 1'b1; repeat (2) tick();
        done[0] = 1'b0; start[3] = 1'b0; ready[3] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rd_metric(0, sels[i], e, g);
            n_checks++;
            if (g !== tab[i]) begin n_bad++; $display("FAIL freeze_hold sel=%0d got=%0d exp=%0d", sels[i], g, tab[i]); end
        end
        n_checks++;
        if (all_idle !== 1'b0 || err !== 4'd0) begin
            n_bad++; $display("FAIL freeze_status idle=%b err=%b exp idle=0 err=0000", all_idle, err);
        end
        do_clear();
        n_checks++;
        if (frozen !== 1'b0 || all_idle !== 1'b1) begin
            n_bad++; $display("FAIL clear_status frozen=%b idle=%b exp 0/1", frozen, all_idle);
        end
        rd_metric(0, 2, e, g);
        n_checks++;
        if (g !== 32'd0) begin n_bad++; $display("FAIL clear_busy got=%0d exp=0", g); end
        rd_metric(0, 4, e, g);
        n_checks++;
        if (g !== 32'h0000_FFFF) begin n_bad++; $display("FAIL clear_min_lat got=%0h exp=ffff", g); end
    endtask

    task automatic test_edges();
        bit [31:0] e; logic [31:0] g;
        do_clear();
        done[3] = 1'b1; tick(); done[3] = 1'b0;
        rd_metric(3, 1, e, g);
        n_checks++;
        if (g !== 32'd0 || err !== 4'b1000) begin
            n_bad++; $display("FAIL orphan_done txn_out=%0d err=%b exp 0/1000", g, err);
        end
        start[0] = 1'b1; ready[0] = 1'b1; done[0] = 1'b1; tick();
        start[0] = 1'b0; ready[0] = 1'b0; done[0] = 1'b0;
        rd_metric(0, 6, e, g);
        n_checks++;
        if (g !== 32'd0 || err[0] !== 1'b0) begin
            n_bad++; $display("FAIL zero_lat last=%0d err0=%b exp 0/0", g, err[0]);
        end
        rd_metric(0, 0, e, g);
        n_checks++;
        if (g !== 32'd1) begin n_bad++; $display("FAIL zero_lat_in got=%0d exp=1", g); end
        rd_metric(0, 1, e, g);
        n_checks++;
        if (g !== 32'd1) begin n_bad++; $display("FAIL zero_lat_out got=%0d exp=1", g); end
    endtask

    task automatic test_saturation();
        bit [31:0] e; logic [31:0] g;
        do_clear();
        start[0] = 1'b1; ready[0] = 1'b1; tick();
        start[0] = 1'b0; ready[0] = 1'b0;
        repeat (69999) tick();
        done[0] = 1'b1; tick(); done[0] = 1'b0;
        rd_metric(0, 6, e, g);
        n_checks++;
        if (g !== 32'd65535) begin n_bad++; $display("FAIL lat_sat got=%0d exp=65535", g); end
        rd_metric(0, 2, e, g);
        n_checks++;
        if (g !== 32'd70000) begin n_bad++; $display("FAIL long_busy got=%0d exp=70000", g); end
        // 4-bit counter build: 24 busy cycles must stick at 15
        s_clear = 1'b1; tick(); s_clear = 1'b0;
        s_start = 1'b1; s_ready = 1'b1; tick();
        s_start = 1'b0; s_ready = 1'b0;
        repeat (24) tick();
        s_rd_sel = 3'd2; tick();
        n_checks++;
        if (s_rd_data !== 4'd15) begin n_bad++; $display("FAIL busy_sat got=%0d exp=15", s_rd_data); end
    endtask

    task automatic test_random();
        bit [31:0] e; logic [31:0] g;
        do_clear();
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int c = 0; c < NCH; c++) begin
                start[c] = ($urandom_range(0, 2) == 0);
                ready[c] = ($urandom_range(0, 3) != 0);
                done[c]  = ($urandom_range(0, 2) == 0);
                cont[c]  = ($urandom_range(0, 3) != 0);
            end
            clear = ($urandom_range(0, 199) == 0);
            tick();
            n_checks++;
            if (err !== m_err || all_idle !== model_idle()) begin
                n_bad++;
                $display("FAIL rand_status cyc=%0d err=%b idle=%b exp err=%b idle=%b",
                         cyc, err, all_idle, m_err, model_idle());
            end
        end
        start = 4'h0; ready = 4'h0; done = 4'h0; cont = 4'hF; clear = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            for (int s = 0; s < 8; s++) begin
                rd_metric(c, s, e, g);
                n_checks++;
                if (g !== e) begin n_bad++; $display("FAIL rand_metric ch=%0d sel=%0d got=%0d exp=%0d", c, s, g, e); end
            end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_single();
        test_pipelined();
        test_stall();
        test_freeze();
        test_edges();
        test_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/ap_ctrl_profiler.md
Name: ap_ctrl_profiler

Overview:
- Synthesizable, multi-channel successor to the simulation-only module/loop status monitors.
- Observes up to NUM_CH ap_ctrl_chain handshake groups: start, ready, done, continue.
- Per channel it accumulates transaction counts, busy and stall cycles, and min/max/last latency, with overlapping (pipelined) transactions supported.
- Statistics are frozen on `finish` and read back through a registered select port. Used by the test harness and for on-chip profiling.

Parameters:
- NUM_CH, 4: number of monitored handshake channels (1..16).
- CNT_W, 32: width of event/cycle counters and of the timestamp.
- LAT_W, 16: width of latency results.
- MAX_OUT, 4: maximum outstanding transactions per channel (timestamp FIFO depth, power of 2).

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- finish  in  1  end-of-run; freezes all statistics (sticky).
- clear  in  1  synchronous statistics clear.
- ch_start  in  NUM_CH  ap_start per channel.
- ch_ready  in  NUM_CH  ap_ready per channel.
- ch_done  in  NUM_CH  ap_done per channel.
- ch_continue  in  NUM_CH  ap_continue per channel; tie to 1 for non-chained channels.
- rd_ch  in  $clog2(NUM_CH)  channel to read.
- rd_sel  in  3  metric select (encoding in package).
- rd_data  out  CNT_W  selected metric, zero-extended.
- rd_valid  out  1  high one cycle after any rd_ch/rd_sel sample, i.e. always 1 after the first post-reset cycle.
- err  out  NUM_CH  sticky protocol error per channel.
- frozen  out  1  statistics frozen.
- all_idle  out  1  no channel has outstanding transactions.

Behaviour:
- Reset:
  - All counters, FIFOs and err are set to 0; min_lat to all ones; frozen=0; rd_data=0; rd_valid=0; all_idle=1.
- Timestamp:
  - Free-running CNT_W counter, wraps modulo 2^CNT_W; increments while !frozen.
- Accept event: ch_start & ch_ready. Push timestamp into the channel FIFO, txn_in++.
- Complete event: ch_done & ch_continue.
  - Pop the FIFO head.
  - lat = (ts - head) mod 2^CNT_W, saturated to 2^LAT_W-1.
  - Update last_lat and max_lat; update min_lat if lat is smaller. txn_out++.
- Accept and complete in the same cycle:
  - FIFO non-empty: pop head and push new timestamp together; occupancy unchanged.
  - FIFO empty: zero-latency transaction; lat=0, counters updated, no push, no error.
- busy_cycles++ every cycle the FIFO is non-empty.
- stall_cycles++ every cycle ch_done & !ch_continue.
- Errors, each setting err[ch] sticky with no other state change for the offending event:
  - Accept while the FIFO is full: event dropped, txn_in unchanged.
  - Complete while the FIFO is empty and no same-cycle accept.
- Counters saturate at 2^CNT_W-1; they never wrap.
- Channel state per channel: IDLE (FIFO empty), ACTIVE (1..MAX_OUT-1 entries), FULL (MAX_OUT entries). Transitions follow FIFO occupancy. all_idle = AND over channels of IDLE.
- finish:
  - On the first cycle finish=1, frozen goes to 1 on the next edge.
  - While frozen, no statistic or timestamp changes; events are ignored.
  - Readout remains live. Only reset or clear leaves frozen.
- clear:
  - Same effect as reset on statistics, FIFOs, err and frozen; rd_data is untouched.
  - Has priority over events in the same cycle.
- Readout:
  - rd_data is registered one cycle after rd_ch/rd_sel.
  - rd_sel values: 0 txn_in, 1 txn_out, 2 busy_cycles, 3 stall_cycles, 4 min_lat, 5 max_lat, 6 last_lat, 7 FIFO occupancy.
  - min_lat reads as all ones (LAT_W bits) until the first completion.
- Reset or clear mid-transaction discards outstanding timestamps; no error is raised.

Decomposition:
- Package ap_prof_pkg:
  - metric-select enum (METRIC_TXN_IN..METRIC_OCC);
  - channel state enum (CH_IDLE, CH_ACTIVE, CH_FULL);
  - LAT_SAT helper function.
- Sub-module ap_prof_channel:
  - one channel's FIFO, counters, latency logic and error flag;
  - instantiated NUM_CH times via generate.
- The top level holds the timestamp, frozen flag and readout mux.

Test Plan:
- Single transaction: start&ready at t=10, done at t=17 on ch0 → txn_in=1, txn_out=1, last/min/max_lat=7, busy_cycles=7, err=0.
- Pipelined, MAX_OUT=4: ch1 accepts at t=0,1,2,3 and completes at t=5,6,7,8 → all latencies 5, occupancy peaks at 4; a 5th accept at t=4 sets err[1] and txn_in stays 4.
- Stall: ch2 done=1 with continue=0 for 3 cycles, then continue=1 → stall_cycles=3, latency includes the stall cycles.
- Freeze: assert finish mid-run with ch0 busy → all metrics constant thereafter, frozen=1, rd_data still follows rd_sel with 1-cycle latency; clear → all zero, min_lat=0xFFFF.
- Error and edge cases:
  - ch3 done without any accept → err[3]=1, txn_out=0.
  - Same-cycle accept+done on an empty FIFO → lat=0, err=0.
- Saturation: CNT_W=4 build, 20 busy cycles → busy_cycles=15; 70000-cycle latency with LAT_W=16 → 65535.
